// File: rtl/ahb_multi_decoder_if.sv
// rtl/ahb_multi_decoder_if.sv - AHB-Lite decoder bus bundle with master/slave modports
interface ahb_multi_decoder_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ERR_CNT_W  = 8
);
    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic [NUM_SLAVES-1:0]        HSEL;
    logic                         HSEL_DEFAULT;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S;
    logic [NUM_SLAVES-1:0]        HREADYOUT_S;
    logic [NUM_SLAVES-1:0]        HRESP_S;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HREADY;
    logic                         HRESP;
    logic [ERR_CNT_W-1:0]         err_cnt;
    logic                         err_cnt_clr;

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S, err_cnt_clr,
        input  HSEL, HSEL_DEFAULT, HRDATA, HREADY, HRESP, err_cnt
    );

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S, err_cnt_clr,
        output HSEL, HSEL_DEFAULT, HRDATA, HREADY, HRESP, err_cnt
    );
endinterface

// File: rtl/ahb_multi_decoder.sv
// rtl/ahb_multi_decoder.sv - parametrised AHB-Lite decoder, response mux and default error slave
module ahb_multi_decoder #(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       ADDR_W     = 32,
    parameter int                       DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_0000}},
    parameter int                       ERR_CNT_W  = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_multi_decoder_if.slave bus
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {DP_NONE, DP_SLV, DP_DEF} dp_kind_t;
    typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_state_t;

    dp_kind_t             r_dp_kind;
    logic [IDX_W-1:0]     r_dp_idx;
    def_state_t           r_def_state;
    def_state_t           w_def_next;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_active;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_idx;
    logic [DATA_W-1:0]    w_hrdata;
    logic                 w_hready;
    logic                 w_hresp;
    logic                 w_def_capture;

    assign w_active = ~HRESET & (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    assign bus.HSEL         = (w_active && w_hit) ? (NUM_SLAVES'(1) << w_idx) : '0;
    assign bus.HSEL_DEFAULT = w_active & ~w_hit;
    assign w_def_capture    = w_hready & w_active & ~w_hit;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dp_kind <= DP_NONE;
            r_dp_idx  <= '0;
        end else if (w_hready) begin
            if (!w_active) begin
                r_dp_kind <= DP_NONE;
                r_dp_idx  <= '0;
            end else if (w_hit) begin
                r_dp_kind <= DP_SLV;
                r_dp_idx  <= w_idx;
            end else begin
                r_dp_kind <= DP_DEF;
                r_dp_idx  <= '0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_def_state <= DEF_IDLE;
        end else begin
            r_def_state <= w_def_next;
        end
    end

    // ERR2 drives HREADY high, so a new unmapped capture there restarts the ERROR pair.
    always_comb begin
        w_def_next = DEF_IDLE;
        case (r_def_state)
            DEF_IDLE: w_def_next = w_def_capture ? DEF_ERR1 : DEF_IDLE;
            DEF_ERR1: w_def_next = DEF_ERR2;
            DEF_ERR2: w_def_next = w_def_capture ? DEF_ERR1 : DEF_IDLE;
            default:  w_def_next = DEF_IDLE;
        endcase
    end

    always_comb begin
        w_hrdata = '0;
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        case (r_dp_kind)
            DP_SLV: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_dp_idx == IDX_W'(i)) begin
                        w_hrdata = bus.HRDATA_S[i*DATA_W +: DATA_W];
                        w_hready = bus.HREADYOUT_S[i];
                        w_hresp  = bus.HRESP_S[i];
                    end
                end
            end
            DP_DEF: begin
                w_hready = (r_def_state != DEF_ERR1);
                w_hresp  = 1'b1;
            end
            default: begin
                w_hrdata = '0;
                w_hready = 1'b1;
                w_hresp  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_err_cnt <= '0;
        end else if (bus.err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (r_def_state == DEF_ERR2 && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.HRDATA  = w_hrdata;
    assign bus.HREADY  = w_hready;
    assign bus.HRESP   = w_hresp;
    assign bus.err_cnt = r_err_cnt;
endmodule
